fft_spectrum_store: RTL and testbench
=====================================

# fft_spectrum_store

Downstream of the FFT control/core stage. Consumes the FFT IP output stream (valid/sop/eop plus signed real/imaginary bins) and computes the power of each bin as re²+im², scaled and saturated. It stores the first FFT_POINT/2 bins of each complete frame into a ping-pong spectrum buffer. The display/readout logic reads one stable, complete spectrum while the next one is written.

## Interface
- FFT_POINT, 256: frame length in bins; must equal 2^BIN_AW.
- BIN_AW, 8: log2(FFT_POINT).
- DATA_W, 16: width of signed fft_re/fft_im.
- OUT_W, 16: width of stored power word (unsigned).
- SHIFT, 16: right shift applied to re²+im² before saturation.

- clk_50m  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fft_valid  in  1  source-valid from FFT core; a bin is transferred on every cycle it is high.
- fft_sop  in  1  first bin of frame; qualified by fft_valid.
- fft_eop  in  1  last bin of frame; qualified by fft_valid.
- fft_re  in  DATA_W  signed real part.
- fft_im  in  DATA_W  signed imaginary part.
- rd_addr  in  BIN_AW-1  bin index to read, 0..FFT_POINT/2-1.
- rd_data  out  OUT_W  power of bin rd_addr from the display bank.
- frame_done  out  1  one-cycle pulse when a new spectrum becomes readable.
- bank_sel  out  1  display bank currently presented on rd_data.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Pipeline: S1 registers re, im, valid, sop, eop and bin index. S2 registers re² and im² (signed, 2*DATA_W bits each). S3 registers the sum (2*DATA_W+1 bits, unsigned) >> SHIFT, saturated to 2^OUT_W-1, and issues the RAM write.
- Buffer: two banks of FFT_POINT/2 × OUT_W words. Write bank = ~bank_sel. Only bins with index < FFT_POINT/2 are written. Bins FFT_POINT/2..FFT_POINT-1 are counted but dropped.
- Control FSM with two states:
  - IDLE: waits for fft_valid&fft_sop. Bins with valid but no sop are ignored.
  - RUN: on valid&sop, the bin index is set to 0 and the FSM enters RUN. Each subsequent valid increments the index.
- Frame end:
  - valid&eop with index == FFT_POINT-1 → good frame; return to IDLE.
  - valid&eop with any other index → bad frame; return to IDLE.
  - Index wraps past FFT_POINT-1 without eop → bad frame; return to IDLE.
  - valid&sop while in RUN → the current frame is bad and a new frame starts immediately at index 0.
- Good frame: when the eop bin leaves S3, bank_sel toggles and frame_done pulses in the same cycle.
- Bad frame: frame_err pulses once, bank_sel is unchanged, and the written half-bank is simply overwritten by the next frame.
- Read: rd_data is registered from bank bank_sel at rd_addr.
- Reset (asynchronous, any time, including mid-frame): FSM=IDLE, index=0, pipeline valids=0, bank_sel=0, frame_done=0, frame_err=0, rd_data=0. RAM contents are undefined after reset; rd_data returns 0 until the first frame_done.

## Timing
- Bin accepted at edge t → RAM write at edge t+3.
- eop accepted at edge t → frame_done=1 and bank_sel toggled after edge t+3. rd_addr presented in the cycle after edge t+3 returns new-bank data after edge t+4.
- Read latency is 1 cycle, independent of write activity.
- The pipeline accepts a bin every cycle. Gaps in fft_valid stall nothing and simply insert bubbles.
- Back-to-back frames (sop in the cycle after eop) are supported with no lost bins.
- A flip and a write in the same cycle: the write targets the new ~bank_sel only from the next cycle. The eop-bin write itself goes to the old write bank.
- No backpressure: the block is always ready.

## Test plan
- Single frame where bin k has re=k, im=0, with SHIFT=0: after frame_done, bank_sel=1, and rd_addr=5 → rd_data=25, rd_addr=127 → 16129.
- Saturation: re=im=-32768 (DATA_W=16) with SHIFT=16 → sum=2^31 → >>16 = 32768 → rd_data=32768. The same input with SHIFT=15 → rd_data=65535 (saturated).
- Two back-to-back frames with constants 1 and 2 (re=1 and re=2, SHIFT=0): frame_done pulses 256 cycles apart, bank_sel goes 1→0, and reads give 1 and then 4.
- eop at index 100: frame_err pulses at t+3, and bank_sel and rd_data are unchanged. A second sop mid-frame at index 50 → one frame_err, and the new frame completes normally.
- Valid bins before any sop are ignored: no writes, no pulses.
- Assert rst_n=0 at index 70 mid-frame: all outputs read 0. After release, the next complete frame produces frame_done with bank_sel=1.

Source files
------------

// File: rtl/fft_spectrum_store_if.sv
// FFT output stream bundle: valid/sop/eop plus signed real/imag bins.
interface fft_spectrum_store_if #(
  parameter int DATA_W = 16
);
  logic                     fft_valid;
  logic                     fft_sop;
  logic                     fft_eop;
  logic signed [DATA_W-1:0] fft_re;
  logic signed [DATA_W-1:0] fft_im;

  modport master (
    output fft_valid, fft_sop, fft_eop,
    output fft_re, fft_im
  );

  modport slave (
    input fft_valid, fft_sop, fft_eop,
    input fft_re, fft_im
  );
endinterface

// File: rtl/fft_spectrum_store.sv
// Bin power (re^2+im^2, scaled, saturated) into a ping-pong spectrum
// buffer; the display bank stays stable while the next frame is written.
module fft_spectrum_store #(
  parameter int FFT_POINT = 256,
  parameter int BIN_AW    = 8,
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 16
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  fft_spectrum_store_if.slave fft,
  input  logic [BIN_AW-2:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              frame_done,
  output logic              bank_sel,
  output logic              frame_err
);
  localparam int SQ_W  = 2 * DATA_W;
  localparam int SUM_W = SQ_W + 1;
  localparam logic [BIN_AW-1:0] LAST = BIN_AW'(FFT_POINT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [BIN_AW-1:0] idx;

  logic              start, take, last_bin;
  logic              good, bad;
  logic [BIN_AW-1:0] cur_idx;

  logic                     s1_vld, s1_good, s1_bad;
  logic [BIN_AW-1:0]        s1_idx;
  logic signed [DATA_W-1:0] s1_re, s1_im;

  logic                   s2_vld, s2_good, s2_bad;
  logic [BIN_AW-1:0]      s2_idx;
  logic signed [SQ_W-1:0] s2_re_sq, s2_im_sq;

  logic [SUM_W-1:0] sum, shifted;
  logic [OUT_W-1:0] pow;

  logic              s3_vld, s3_good, s3_bad;
  logic [BIN_AW-1:0] s3_idx;
  logic [OUT_W-1:0]  s3_pow;

  logic              have;
  logic [OUT_W-1:0]  mem [FFT_POINT];

  // eop off the last index, or the last index without eop, both end badly
  always_comb begin
    start    = fft.fft_valid & fft.fft_sop;
    take     = start | (fft.fft_valid & (state == RUN));
    cur_idx  = start ? '0 : idx + 1'b1;
    last_bin = (cur_idx == LAST);
    good     = take & fft.fft_eop & last_bin;
    bad      = (start & (state == RUN))
             | (take & (fft.fft_eop ^ last_bin));
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      s1_vld  <= 1'b0;
      s1_good <= 1'b0;
      s1_bad  <= 1'b0;
      s1_idx  <= '0;
      s1_re   <= '0;
      s1_im   <= '0;
    end else begin
      s1_vld  <= take;
      s1_good <= good;
      s1_bad  <= bad;
      s1_idx  <= cur_idx;
      s1_re   <= fft.fft_re;
      s1_im   <= fft.fft_im;
      if (take) begin
        idx   <= cur_idx;
        state <= (fft.fft_eop | last_bin) ? IDLE : RUN;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_good  <= 1'b0;
      s2_bad   <= 1'b0;
      s2_idx   <= '0;
      s2_re_sq <= '0;
      s2_im_sq <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_good  <= s1_good;
      s2_bad   <= s1_bad;
      s2_idx   <= s1_idx;
      s2_re_sq <= SQ_W'(s1_re) * SQ_W'(s1_re);
      s2_im_sq <= SQ_W'(s1_im) * SQ_W'(s1_im);
    end
  end

  always_comb begin
    sum     = {1'b0, s2_re_sq} + {1'b0, s2_im_sq};
    shifted = sum >> SHIFT;
    pow     = (|shifted[SUM_W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      s3_vld  <= 1'b0;
      s3_good <= 1'b0;
      s3_bad  <= 1'b0;
      s3_idx  <= '0;
      s3_pow  <= '0;
    end else begin
      s3_vld  <= s2_vld;
      s3_good <= s2_good;
      s3_bad  <= s2_bad;
      s3_idx  <= s2_idx;
      s3_pow  <= pow;
    end
  end

  // the eop-bin write still lands in the old write bank on the flip edge
  always_ff @(posedge clk_50m) begin
    if (s3_vld && !s3_idx[BIN_AW-1])
      mem[{~bank_sel, s3_idx[BIN_AW-2:0]}] <= s3_pow;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      have       <= 1'b0;
    end else begin
      frame_done <= s3_vld & s3_good;
      frame_err  <= s3_vld & s3_bad;
      if (s3_vld && s3_good) begin
        bank_sel <= ~bank_sel;
        have     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else
      rd_data <= have ? mem[{bank_sel, rd_addr}] : '0;
  end
endmodule

// File: tb/tb_fft_spectrum_store.sv
// Randomized frame-level bench for fft_spectrum_store, three SHIFT variants
// sharing one stream, checked against a frame-assembly reference model.
module tb_fft_spectrum_store;
  localparam int NP = 256;
  localparam int HP = 128;
  localparam logic [2:0][4:0] SH = {5'd15, 5'd16, 5'd0};

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  fft_spectrum_store_if #(.DATA_W(16)) s ();
  logic [6:0]  rd_addr;
  logic [15:0] rdat [3];
  logic [2:0]  done, bsel, ferr;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fft_spectrum_store #(
      .FFT_POINT(256), .BIN_AW(8), .DATA_W(16),
      .OUT_W(16), .SHIFT(int'(SH[g]))
    ) u (
      .clk_50m(clk), .rst_n(rst_n), .fft(s),
      .rd_addr(rd_addr), .rd_data(rdat[g]),
      .frame_done(done[g]), .bank_sel(bsel[g]),
      .frame_err(ferr[g])
    );
  end

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_done = 0, n_err = 0;
  int done_cyc = 0, prev_done_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done[0]) begin
        n_done++;
        prev_done_cyc = done_cyc;
        done_cyc = cyc;
      end
      if (ferr[0]) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  // reference model: frames assembled bin by bin from the stream rules
  bit m_run = 0;
  int m_cnt = 0;
  int cur_re [HP], cur_im [HP];
  int exp_re [HP], exp_im [HP];
  int exp_done = 0, exp_err = 0;
  bit exp_bank = 0, exp_have = 0;
  int eop_edge = 0;

  function automatic int pw(input int re, input int im, input int sh);
    longint p;
    p = (longint'(re) * re + longint'(im) * im) >> sh;
    return (p > 65535) ? 65535 : int'(p);
  endfunction

  function automatic int rnd();
    if ($urandom_range(1) == 0)
      return int'($urandom_range(360)) - 180;
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic model_bin(input int re, input int im,
                           input bit sop, input bit eop);
    if (sop) begin
      if (m_run) exp_err++;
      m_run = 1;
      m_cnt = 0;
    end else if (!m_run) begin
      return;
    end
    if (m_cnt < HP) begin
      cur_re[m_cnt] = re;
      cur_im[m_cnt] = im;
    end
    m_cnt++;
    if (eop || m_cnt == NP) begin
      m_run = 0;
      if (eop && m_cnt == NP) begin
        exp_re   = cur_re;
        exp_im   = cur_im;
        exp_done++;
        exp_bank = ~exp_bank;
        exp_have = 1;
      end else begin
        exp_err++;
      end
    end
  endtask

  task automatic drive(input bit v, input int re, input int im,
                       input bit sop, input bit eop);
    @(negedge clk);
    s.fft_valid = v;
    s.fft_sop   = sop;
    s.fft_eop   = eop;
    s.fft_re    = 16'(re);
    s.fft_im    = 16'(im);
    if (v && eop) eop_edge = cyc + 1;
    if (v) model_bin(re, im, sop, eop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  // kind 0: ramp re=i; 1: constants ca/cb; else random
  task automatic frame(input int n, input bit eop_last, input int kind,
                       input int ca, input int cb, input int gap);
    int re, im;
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && int'($urandom_range(99)) < gap)
        drive(0, 0, 0, 0, 0);
      case (kind)
        0:       begin re = i;     im = 0;     end
        1:       begin re = ca;    im = cb;    end
        default: begin re = rnd(); im = rnd(); end
      endcase
      drive(1, re, im, i == 0, eop_last && i == n - 1);
    end
  endtask

  task automatic rd(input int a);
    @(negedge clk);
    rd_addr = 7'(a);
    @(negedge clk);
  endtask

  task automatic check_spectrum(input string name);
    int e;
    @(negedge clk);
    rd_addr = 0;
    for (int k = 0; k < HP; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        e = exp_have ? pw(exp_re[k], exp_im[k], int'(SH[g])) : 0;
        tests++;
        if (rdat[g] !== 16'(e)) begin
          fails++;
          $display("FAIL %s dut%0d bin %0d: got %0d expected %0d",
                   name, g, k, rdat[g], e);
        end
      end
      rd_addr = 7'(k + 1);
    end
  endtask

  task automatic check_status(input string name);
    tests++;
    if (bsel[0] !== exp_bank) begin
      fails++;
      $display("FAIL %s bank_sel: got %0b expected %0b",
               name, bsel[0], exp_bank);
    end
    tests++;
    if (n_done !== exp_done) begin
      fails++;
      $display("FAIL %s frame_done count: got %0d expected %0d",
               name, n_done, exp_done);
    end
    tests++;
    if (n_err !== exp_err) begin
      fails++;
      $display("FAIL %s frame_err count: got %0d expected %0d",
               name, n_err, exp_err);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    for (int g = 0; g < 3; g++) begin
      tests++;
      if (rdat[g] !== 16'd0 || done[g] !== 1'b0 ||
          bsel[g] !== 1'b0 || ferr[g] !== 1'b0) begin
        fails++;
        $display("FAIL %s dut%0d: got rd=%0d done=%0b bank=%0b err=%0b expected all 0",
                 name, g, rdat[g], done[g], bsel[g], ferr[g]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1;
    idle(2);
    check_status("reset");
  endtask

  task automatic test_pre_sop();
    for (int i = 0; i < 20; i++)
      drive(1, rnd(), rnd(), 0, (i == 10) || (i == 19));
    idle(6);
    check_status("pre_sop");
    check_spectrum("pre_sop");
  endtask

  task automatic test_ramp();
    frame(NP, 1, 0, 0, 0, 0);
    idle(6);
    check_status("ramp");
    tests++;
    if (done_cyc - eop_edge !== 3) begin
      fails++;
      $display("FAIL ramp done latency: got %0d expected 3",
               done_cyc - eop_edge);
    end
    tests++;
    if (bsel[0] !== 1'b1) begin
      fails++;
      $display("FAIL ramp bank_sel: got %0b expected 1", bsel[0]);
    end
    rd(5);
    tests++;
    if (rdat[0] !== 16'd25) begin
      fails++;
      $display("FAIL ramp bin5: got %0d expected 25", rdat[0]);
    end
    rd(127);
    tests++;
    if (rdat[0] !== 16'd16129) begin
      fails++;
      $display("FAIL ramp bin127: got %0d expected 16129", rdat[0]);
    end
    check_spectrum("ramp");
  endtask

  task automatic test_saturation();
    frame(NP, 1, 1, -32768, -32768, 0);
    idle(6);
    check_status("saturation");
    rd(0);
    tests++;
    if (rdat[1] !== 16'd32768) begin
      fails++;
      $display("FAIL sat shift16: got %0d expected 32768", rdat[1]);
    end
    tests++;
    if (rdat[2] !== 16'd65535) begin
      fails++;
      $display("FAIL sat shift15: got %0d expected 65535", rdat[2]);
    end
    check_spectrum("saturation");
  endtask

  task automatic test_back_to_back();
    rd_addr = 0;
    frame(NP, 1, 1, 1, 0, 0);
    for (int i = 0; i < NP; i++) begin
      drive(1, 2, 0, i == 0, i == NP - 1);
      if (i == 10) begin
        tests++;
        if (rdat[0] !== 16'd1 || bsel[0] !== 1'b1) begin
          fails++;
          $display("FAIL b2b first: got rd=%0d bank=%0b expected rd=1 bank=1",
                   rdat[0], bsel[0]);
        end
      end
    end
    idle(6);
    tests++;
    if (done_cyc - prev_done_cyc !== 256) begin
      fails++;
      $display("FAIL b2b done spacing: got %0d expected 256",
               done_cyc - prev_done_cyc);
    end
    check_status("b2b");
    rd(0);
    tests++;
    if (rdat[0] !== 16'd4 || bsel[0] !== 1'b0) begin
      fails++;
      $display("FAIL b2b second: got rd=%0d bank=%0b expected rd=4 bank=0",
               rdat[0], bsel[0]);
    end
    check_spectrum("b2b");
  endtask

  task automatic test_bad_eop();
    frame(101, 1, 2, 0, 0, 20);
    idle(6);
    tests++;
    if (err_cyc - eop_edge !== 3) begin
      fails++;
      $display("FAIL bad_eop err latency: got %0d expected 3",
               err_cyc - eop_edge);
    end
    check_status("bad_eop");
    check_spectrum("bad_eop");
  endtask

  task automatic test_mid_sop();
    frame(50, 0, 2, 0, 0, 0);
    frame(NP, 1, 2, 0, 0, 25);
    idle(6);
    check_status("mid_sop");
    check_spectrum("mid_sop");
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      frame(NP, 1, 2, 0, 0, 30);
      idle(6);
      check_status("random");
      check_spectrum("random");
    end
  endtask

  task automatic test_reset_mid();
    frame(70, 0, 2, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 0;
    s.fft_valid = 0;
    m_run = 0;
    exp_bank = 0;
    exp_have = 0;
    #1;
    check_zero_outputs("reset_mid");
    @(negedge clk);
    rst_n = 1;
    idle(2);
    check_spectrum("reset_mid_empty");
    frame(NP, 1, 2, 0, 0, 10);
    idle(6);
    check_status("reset_mid");
    tests++;
    if (bsel[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid bank_sel: got %0b expected 1", bsel[0]);
    end
    check_spectrum("reset_mid");
  endtask

  initial begin
    rst_n = 0;
    rd_addr = 0;
    s.fft_valid = 0;
    s.fft_sop = 0;
    s.fft_eop = 0;
    s.fft_re = 0;
    s.fft_im = 0;
    test_reset();
    test_pre_sop();
    test_ramp();
    test_saturation();
    test_back_to_back();
    test_bad_eop();
    test_mid_sop();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
